tipi_bus_ctrl: RTL and testbench
================================

Name: tipi_bus_ctrl

Overview:
Synchronous TI-bus controller for the TIPI CPLD/FPGA, clocked from the 50 MHz board clock. It synchronizes and glitch-filters the asynchronous TI memory and CRU strobes, then decodes TI memory cycles. It latches TI writes into the TI→RPi data/control registers and sequences the active-low output enables of the three bus transmitters. It also owns the device CRU bits that enable the DSR and request an RPi reset.

Parameters:
SYNC_STAGES, 2, flop depth of every TI input synchronizer (≥2)
WE_FILTER, 3, consecutive synchronized-low ti_we samples required to accept a write (≥1)
TD_ADDR, 16'h5fff, TI→RPi data register (write)
TC_ADDR, 16'h5ffd, TI→RPi control register (write)
RD_ADDR, 16'h5ffb, RPi→TI data (read, enables tipi_data_out)
RC_ADDR, 16'h5ff9, RPi→TI control (read, enables tipi_control_out)

Ports:
clk  in  1  50 MHz clock
rst  in  1  synchronous reset, active-high
ti_a  in  [0:15]  TI address, bit 0 = MSB
ti_data  in  [7:0]  TI data bus, bit 7 = MSB
ti_memen  in  1  memory enable, active low
ti_we  in  1  write enable, active low
ti_dbin  in  1  memory read, active high
ti_cruclk  in  1  CRU clock, active low
ti_reset  in  1  TI system reset, active low
cru_base  in  [3:0]  CRU base nibble n in 0x1n00
rpi_d  out  [7:0]  latched TD register
rpi_s  out  [7:0]  latched TC register
td_stb  out  1  one-clk pulse when TD is written
tc_stb  out  1  one-clk pulse when TC is written
tipi_data_out  out  1  RD transmitter OE*, active low
tipi_control_out  out  1  RC transmitter OE*, active low
tipi_dsr_out  out  1  DSR ROM transmitter OE*, active low
dsr_en  out  1  CRU bit 0
rpi_reset_req  out  1  CRU bit 1

Behaviour:
- Sync: ti_a, ti_data, ti_cruclk, cru_base, ti_memen, ti_we, ti_dbin and ti_reset all pass through SYNC_STAGES flops, so address and data stay aligned with the strobes. The outputs are named s_*. On rst the synchronizers load inactive values: memen=1, we=1, dbin=0, cruclk=1, reset=1, and a/data=0.
- Reset values: rpi_d=0, rpi_s=0, strobes=0, all OE*=1, dsr_en=0, rpi_reset_req=0, FSM=IDLE, we_cnt=0.
- Priority: rst > s_ti_reset=0 > FSM/CRU. While s_ti_reset=0, the block applies the same clears as rst, except that the synchronizers keep running.
- FSM:
  - IDLE: s_memen=0 → ACCESS.
  - ACCESS:
    - s_memen=1 → IDLE, clear we_cnt.
    - s_we=0 → we_cnt+1, saturating. When we_cnt reaches WE_FILTER-1 while s_we=0 → WRITE.
    - s_we=1 → clear we_cnt.
    - s_dbin=1, dsr_en=1 and a read decode hit → READ.
  - WRITE: one cycle.
    - dsr_en=1 and s_a==TD_ADDR → rpi_d<=s_data, td_stb=1.
    - dsr_en=1 and s_a==TC_ADDR → rpi_s<=s_data, tc_stb=1.
    - No decode hit or dsr_en=0 → nothing latched.
    - Always → WAIT_WE.
  - WAIT_WE: stay until s_we=1, then go to ACCESS if s_memen=0, else IDLE. This allows the second byte write of a multiplexed word while memen is still low.
  - READ: registered OE* low for the decoded target.
    - s_a==RD_ADDR → tipi_data_out.
    - s_a==RC_ADDR → tipi_control_out.
    - 0x4000 ≤ s_a ≤ 0x5ff7 → tipi_dsr_out.
    - Exit when s_memen=1, s_dbin=0, dsr_en=0, or s_a leaves the decoded target. All OE* return high on the next clk. Next state is ACCESS if s_memen=0, else IDLE.
  - At most one OE* is low at any time. OE* is never low outside READ.
- Latency: from the async strobe to the OE* change is SYNC_STAGES+1 clk, which must stay under 100 ns. From the WE fall to td_stb it is SYNC_STAGES+WE_FILTER+1 clk.
- CRU:
  - A falling edge of s_cruclk (prev=1, now=0) is a hit when s_a[0:3]==4'h1, s_a[4:7]==cru_base and s_a[8:13]==0.
  - On a hit, s_a[14] selects the bit: 0 → dsr_en<=s_a[15]; 1 → rpi_reset_req<=s_a[15].
  - CRU writes are independent of the FSM state. CRU and memory events in the same clk both take effect.
- A WE glitch shorter than WE_FILTER samples latches nothing. A WE that stays low past the filter produces exactly one strobe.
- Reset mid-cycle returns to IDLE. The in-flight write is lost and the OE*s rise the next clk.

Test Plan:
- CRU write addr 0x1200, a15=1, cru_base=2 → dsr_en=1. Then memen=0, a=0x5fff, data=0xA5, WE low for 5 clk → rpi_d=0xA5 and exactly one td_stb pulse.
- dsr_en=0, same write to 0x5ffd with data 0x3C → rpi_s unchanged at 0, tc_stb never asserted.
- dsr_en=1, memen=0, dbin=1, a=0x5ffb → tipi_data_out low SYNC_STAGES+1 clk later while the others stay high. dbin falls → tipi_data_out high next clk. Repeat with 0x5ff9 and 0x4010 for the other two OE*s.
- Memen held low with two WE pulses, to 0x5fff (0x12) then 0x5ffd (0x34) → rpi_d=0x12, rpi_s=0x34, one pulse on each strobe.
- WE low for 2 clk with WE_FILTER=3 → no latch. ti_reset low for 4 clk during READ at 0x4000 → all OE* high, dsr_en=0, rpi_d=rpi_s=0.
- CRU addr 0x1202, a15=1 → rpi_reset_req=1 with dsr_en unchanged. CRU hit on a different base (cru_base=3) → no change.

Source files
------------

// File: rtl/tipi_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tipi_bus_ctrl
// Description : TI-99/4A bus controller for TIPI. Synchronizes the TI bus,
//               filters write strobes, latches TI->RPi data/control bytes,
//               sequences the active-low transmitter output enables and holds
//               the device CRU bits (DSR enable, RPi reset request).
// Revision    : 1.0 - initial release
// ============================================================================
module tipi_bus_ctrl #(
    parameter int          SYNC_STAGES = 2,
    parameter int          WE_FILTER   = 3,
    parameter logic [15:0] TD_ADDR     = 16'h5fff,
    parameter logic [15:0] TC_ADDR     = 16'h5ffd,
    parameter logic [15:0] RD_ADDR     = 16'h5ffb,
    parameter logic [15:0] RC_ADDR     = 16'h5ff9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:15] ti_a,
    input  logic [7:0]  ti_data,
    input  logic        ti_memen,
    input  logic        ti_we,
    input  logic        ti_dbin,
    input  logic        ti_cruclk,
    input  logic        ti_reset,
    input  logic [3:0]  cru_base,
    output logic [7:0]  rpi_d,
    output logic [7:0]  rpi_s,
    output logic        td_stb,
    output logic        tc_stb,
    output logic        tipi_data_out,
    output logic        tipi_control_out,
    output logic        tipi_dsr_out,
    output logic        dsr_en,
    output logic        rpi_reset_req
);

    // All bus inputs travel through one packed synchronizer so that address
    // and data stay cycle-aligned with the strobes that qualify them.
    localparam int          c_SW       = 33;
    localparam logic [c_SW-1:0] c_SYNC_RST = {16'h0000, 8'h00, 1'b1, 4'h0,
                                              1'b1, 1'b1, 1'b0, 1'b1};
    localparam int          c_CW       = $clog2(WE_FILTER + 1);
    localparam logic [c_CW-1:0] c_WE_LAST  = c_CW'(WE_FILTER - 1);
    localparam logic [15:0] c_DSR_LO   = 16'h4000;
    localparam logic [15:0] c_DSR_HI   = 16'h5ff7;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_ACCESS  = 3'd1;
    localparam logic [2:0] c_ST_WRITE   = 3'd2;
    localparam logic [2:0] c_ST_WAIT_WE = 3'd3;
    localparam logic [2:0] c_ST_READ    = 3'd4;

    logic [c_SW-1:0] w_raw;
    logic [c_SW-1:0] r_sync [SYNC_STAGES];
    logic [c_SW-1:0] w_s;

    logic [15:0] w_s_a;
    logic [7:0]  w_s_data;
    logic        w_s_cruclk;
    logic [3:0]  w_s_base;
    logic        w_s_memen;
    logic        w_s_we;
    logic        w_s_dbin;
    logic        w_s_reset;

    logic [2:0]      r_state;
    logic [c_CW-1:0] r_we_cnt;
    logic [7:0]      r_rpi_d;
    logic [7:0]      r_rpi_s;
    logic            r_td_stb;
    logic            r_tc_stb;
    logic [2:0]      r_oe_n;      // {data, control, dsr}, active low
    logic            r_dsr_en;
    logic            r_rpi_reset_req;
    logic            r_cruclk_prev;

    logic [2:0] w_rd_oe_n;
    logic       w_rd_hit;
    logic       w_cru_hit;

    // ti_a[0] is the MSB, so packing it first yields a plain numeric address.
    assign w_raw = {ti_a, ti_data, ti_cruclk, cru_base,
                    ti_memen, ti_we, ti_dbin, ti_reset};
    assign w_s   = r_sync[SYNC_STAGES-1];
    assign {w_s_a, w_s_data, w_s_cruclk, w_s_base,
            w_s_memen, w_s_we, w_s_dbin, w_s_reset} = w_s;

    // Input synchronizer chain, loaded with inactive bus levels on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= c_SYNC_RST;
            end
        end else begin
            r_sync[0] <= w_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Read target decode; targets are disjoint so at most one enable is low
    always_comb begin
        w_rd_oe_n = 3'b111;
        if (w_s_a == RD_ADDR) begin
            w_rd_oe_n = 3'b011;
        end else if (w_s_a == RC_ADDR) begin
            w_rd_oe_n = 3'b101;
        end else if (w_s_a >= c_DSR_LO && w_s_a <= c_DSR_HI) begin
            w_rd_oe_n = 3'b110;
        end
    end
    assign w_rd_hit = (w_rd_oe_n != 3'b111);

    // CRU hit: falling cruclk at 0x1n00 with bits 8..13 clear; bit 14 selects
    // the device bit and bit 15 carries the value.
    assign w_cru_hit = r_cruclk_prev && !w_s_cruclk &&
                       (w_s_a[15:12] == 4'h1) &&
                       (w_s_a[11:8] == w_s_base) &&
                       (w_s_a[7:2] == 6'd0);

    // Previous synchronized cruclk for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cruclk_prev <= 1'b1;
        end else begin
            r_cruclk_prev <= w_s_cruclk;
        end
    end

    // Memory-cycle FSM, register latching, output enables and CRU bits
    always_ff @(posedge clk) begin
        if (rst || !w_s_reset) begin
            r_state         <= c_ST_IDLE;
            r_we_cnt        <= '0;
            r_rpi_d         <= 8'h00;
            r_rpi_s         <= 8'h00;
            r_td_stb        <= 1'b0;
            r_tc_stb        <= 1'b0;
            r_oe_n          <= 3'b111;
            r_dsr_en        <= 1'b0;
            r_rpi_reset_req <= 1'b0;
        end else begin
            r_td_stb <= 1'b0;
            r_tc_stb <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_oe_n <= 3'b111;
                    if (!w_s_memen) begin
                        r_state <= c_ST_ACCESS;
                    end
                end
                c_ST_ACCESS: begin
                    if (w_s_memen) begin
                        r_state  <= c_ST_IDLE;
                        r_we_cnt <= '0;
                    end else if (!w_s_we) begin
                        if (r_we_cnt == c_WE_LAST) begin
                            r_we_cnt <= '0;
                            r_state  <= c_ST_WRITE;
                        end else begin
                            r_we_cnt <= r_we_cnt + c_CW'(1);
                        end
                    end else begin
                        r_we_cnt <= '0;
                        if (w_s_dbin && r_dsr_en && w_rd_hit) begin
                            r_oe_n  <= w_rd_oe_n;
                            r_state <= c_ST_READ;
                        end
                    end
                end
                c_ST_WRITE: begin
                    if (r_dsr_en && w_s_a == TD_ADDR) begin
                        r_rpi_d  <= w_s_data;
                        r_td_stb <= 1'b1;
                    end else if (r_dsr_en && w_s_a == TC_ADDR) begin
                        r_rpi_s  <= w_s_data;
                        r_tc_stb <= 1'b1;
                    end
                    r_state <= c_ST_WAIT_WE;
                end
                c_ST_WAIT_WE: begin
                    // Holding here until WE rises permits a second byte
                    // write while memen stays low.
                    if (w_s_we) begin
                        r_state <= w_s_memen ? c_ST_IDLE : c_ST_ACCESS;
                    end
                end
                c_ST_READ: begin
                    if (w_s_memen || !w_s_dbin || !r_dsr_en ||
                        (w_rd_oe_n != r_oe_n)) begin
                        r_oe_n  <= 3'b111;
                        r_state <= w_s_memen ? c_ST_IDLE : c_ST_ACCESS;
                    end
                end
                default: begin
                    r_oe_n  <= 3'b111;
                    r_state <= c_ST_IDLE;
                end
            endcase

            if (w_cru_hit) begin
                if (w_s_a[1]) begin
                    r_rpi_reset_req <= w_s_a[0];
                end else begin
                    r_dsr_en <= w_s_a[0];
                end
            end
        end
    end

    assign rpi_d            = r_rpi_d;
    assign rpi_s            = r_rpi_s;
    assign td_stb           = r_td_stb;
    assign tc_stb           = r_tc_stb;
    assign tipi_data_out    = r_oe_n[2];
    assign tipi_control_out = r_oe_n[1];
    assign tipi_dsr_out     = r_oe_n[0];
    assign dsr_en           = r_dsr_en;
    assign rpi_reset_req    = r_rpi_reset_req;

endmodule
`default_nettype wire

// File: tb/tb_tipi_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tipi_bus_ctrl
// Description : Self-checking bench for tipi_bus_ctrl. Expected strobe data
//               is queued when a write is driven and compared when the DUT
//               pulses td_stb / tc_stb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tipi_bus_ctrl;

    localparam int SYNC_STAGES = 2;
    localparam int WE_FILTER   = 3;

    logic        clk;
    logic        rst;
    logic [0:15] ti_a;
    logic [7:0]  ti_data;
    logic        ti_memen;
    logic        ti_we;
    logic        ti_dbin;
    logic        ti_cruclk;
    logic        ti_reset;
    logic [3:0]  cru_base;
    logic [7:0]  rpi_d;
    logic [7:0]  rpi_s;
    logic        td_stb;
    logic        tc_stb;
    logic        tipi_data_out;
    logic        tipi_control_out;
    logic        tipi_dsr_out;
    logic        dsr_en;
    logic        rpi_reset_req;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q_td [$];
    logic [7:0] q_tc [$];

    logic [2:0] w_oe;
    assign w_oe = {tipi_data_out, tipi_control_out, tipi_dsr_out};

    tipi_bus_ctrl #(
        .SYNC_STAGES (SYNC_STAGES),
        .WE_FILTER   (WE_FILTER)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .ti_a             (ti_a),
        .ti_data          (ti_data),
        .ti_memen         (ti_memen),
        .ti_we            (ti_we),
        .ti_dbin          (ti_dbin),
        .ti_cruclk        (ti_cruclk),
        .ti_reset         (ti_reset),
        .cru_base         (cru_base),
        .rpi_d            (rpi_d),
        .rpi_s            (rpi_s),
        .td_stb           (td_stb),
        .tc_stb           (tc_stb),
        .tipi_data_out    (tipi_data_out),
        .tipi_control_out (tipi_control_out),
        .tipi_dsr_out     (tipi_dsr_out),
        .dsr_en           (dsr_en),
        .rpi_reset_req    (rpi_reset_req)
    );

    // 50 MHz clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (td_stb) begin
                if (q_td.size() == 0) check_val("td_stb_unexpected", td_stb, 1'b0);
                else                  check_val("rpi_d", rpi_d, q_td.pop_front());
            end
            if (tc_stb) begin
                if (q_tc.size() == 0) check_val("tc_stb_unexpected", tc_stb, 1'b0);
                else                  check_val("rpi_s", rpi_s, q_tc.pop_front());
            end
        end
    end

    task automatic mem_write(input logic [15:0] addr, input logic [7:0] data,
                             input int nlow);
        ti_a     = addr;
        ti_data  = data;
        ti_memen = 1'b0;
        step(3);
        ti_we = 1'b0;
        step(nlow);
        ti_we = 1'b1;
        step(4);
    endtask

    task automatic mem_release();
        ti_memen = 1'b1;
        step(4);
    endtask

    task automatic cru_write(input logic [15:0] addr);
        ti_a = addr;
        step(3);
        ti_cruclk = 1'b0;
        step(3);
        ti_cruclk = 1'b1;
        step(4);
    endtask

    // OE* must change exactly SYNC_STAGES+1 clocks after dbin rises / falls
    task automatic read_test(input logic [15:0] addr, input logic [2:0] exp_oe,
                             input string tag);
        ti_memen = 1'b0;
        ti_a     = addr;
        step(4);
        ti_dbin = 1'b1;
        repeat (SYNC_STAGES) @(posedge clk);
        @(negedge clk) check_val({tag, "_oe_early"}, w_oe, 3'b111);
        @(posedge clk);
        @(negedge clk) check_val({tag, "_oe_on"}, w_oe, exp_oe);
        step(3);
        ti_dbin = 1'b0;
        repeat (SYNC_STAGES) @(posedge clk);
        @(negedge clk) check_val({tag, "_oe_hold"}, w_oe, exp_oe);
        @(posedge clk);
        @(negedge clk) check_val({tag, "_oe_off"}, w_oe, 3'b111);
        step(1);
        mem_release();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        ti_a      = 16'h0000;
        ti_data   = 8'h00;
        ti_memen  = 1'b1;
        ti_we     = 1'b1;
        ti_dbin   = 1'b0;
        ti_cruclk = 1'b1;
        ti_reset  = 1'b1;
        cru_base  = 4'h2;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_rpi_d", rpi_d, 8'h00);
        check_val("rst_rpi_s", rpi_s, 8'h00);
        check_val("rst_oe", w_oe, 3'b111);
        check_val("rst_dsr_en", dsr_en, 1'b0);
        check_val("rst_reset_req", rpi_reset_req, 1'b0);
        step(2);

        // Write with DSR disabled: nothing latched, no strobe
        mem_write(16'h5ffd, 8'h3c, 5);
        mem_release();
        check_val("dis_rpi_s", rpi_s, 8'h00);

        // Enable DSR via CRU bit 0 at base 0x1200
        cru_write(16'h1201);
        check_val("cru_dsr_en", dsr_en, 1'b1);

        // Single TD write, WE held past the filter
        q_td.push_back(8'ha5);
        mem_write(16'h5fff, 8'ha5, 5);
        mem_release();

        // The three read targets
        read_test(16'h5ffb, 3'b011, "rd");
        read_test(16'h5ff9, 3'b101, "rc");
        read_test(16'h4010, 3'b110, "dsr");

        // Two byte writes within one memen-low cycle
        q_td.push_back(8'h12);
        mem_write(16'h5fff, 8'h12, 4);
        q_tc.push_back(8'h34);
        mem_write(16'h5ffd, 8'h34, 4);
        mem_release();

        // WE glitch shorter than the filter
        mem_write(16'h5fff, 8'h77, WE_FILTER - 1);
        mem_release();
        check_val("glitch_rpi_d", rpi_d, 8'h12);

        // TI reset during a DSR read
        ti_memen = 1'b0;
        ti_a     = 16'h4000;
        step(4);
        ti_dbin = 1'b1;
        step(5);
        check_val("pre_rst_oe", w_oe, 3'b110);
        ti_reset = 1'b0;
        step(4);
        check_val("tirst_oe", w_oe, 3'b111);
        check_val("tirst_dsr_en", dsr_en, 1'b0);
        check_val("tirst_rpi_d", rpi_d, 8'h00);
        check_val("tirst_rpi_s", rpi_s, 8'h00);
        ti_reset = 1'b1;
        ti_dbin  = 1'b0;
        ti_memen = 1'b1;
        step(5);

        // CRU bit 1 sets the reset request, bit 0 untouched
        cru_write(16'h1203);
        check_val("cru_reset_req", rpi_reset_req, 1'b1);
        check_val("cru_dsr_keep", dsr_en, 1'b0);

        // Wrong base: clearing bit 1 at 0x1200 must be ignored
        cru_base = 4'h3;
        step(3);
        cru_write(16'h1202);
        check_val("cru_base_miss", rpi_reset_req, 1'b1);
        cru_write(16'h1301);
        check_val("cru_base3_hit", dsr_en, 1'b1);

        check_val("td_queue_left", q_td.size(), 0);
        check_val("tc_queue_left", q_tc.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
